axi_read_arbiter: RTL and testbench

- Shares one AXI4 read master port (AR + R channels) between two read requesters: requester 0 is the Icache line-fill port and requester 1 is the data-cache fill port.
- Allows one outstanding burst at a time. Arbitration is round-robin and the grant is held from the AR handshake through the R beat that carries rlast.
- Sits between the caches and the top-level memory interface. It also checks the beat count of each burst and records a sticky protocol error.

---
 rtl/axi_read_arbiter.sv | 103 ++++++++++
 tb/tb_axi_read_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin share of one AXI4 read master between the
// icache (requester 0) and dcache (requester 1); one burst outstanding at a time.
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*ID_WIDTH-1:0]   s_arid,
  input  logic [2*ADDR_WIDTH-1:0] s_araddr,
  input  logic [15:0]             s_arlen,
  input  logic [5:0]              s_arsize,
  input  logic [3:0]              s_arburst,
  input  logic [1:0]              s_arlock,
  input  logic [7:0]              s_arcache,
  input  logic [5:0]              s_arprot,
  input  logic [1:0]              s_arvalid,
  output logic [1:0]              s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic [1:0]              s_rvalid,
  input  logic [1:0]              s_rready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    grant,
  output logic                    busy,
  output logic                    protocol_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic last_grant, pick, ar_hs, r_hs;
  logic [7:0] exp_len, beat_cnt;

  assign pick  = &s_arvalid ? ~last_grant : s_arvalid[1];
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;
  assign busy  = state != IDLE;

  assign m_axi_arid    = s_arid[grant*ID_WIDTH +: ID_WIDTH];
  assign m_axi_araddr  = s_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axi_arlen   = s_arlen[grant*8 +: 8];
  assign m_axi_arsize  = s_arsize[grant*3 +: 3];
  assign m_axi_arburst = s_arburst[grant*2 +: 2];
  assign m_axi_arlock  = s_arlock[grant];
  assign m_axi_arcache = s_arcache[grant*4 +: 4];
  assign m_axi_arprot  = s_arprot[grant*3 +: 3];

  assign s_rid   = m_axi_rid;
  assign s_rdata = m_axi_rdata;
  assign s_rresp = m_axi_rresp;
  assign s_rlast = m_axi_rlast;

  always_comb begin
    s_arready = '0;
    s_rvalid = '0;
    m_axi_arvalid = state == ADDR;
    m_axi_rready = (state == DATA) & s_rready[grant];
    s_arready[grant] = m_axi_arvalid & m_axi_arready;
    s_rvalid[grant] = (state == DATA) & m_axi_rvalid;
    state_n = (state == IDLE && |s_arvalid)        ? ADDR :
              (state == ADDR && ar_hs)             ? DATA :
              (state == DATA && r_hs && m_axi_rlast) ? IDLE : state;
  end

  // a non-last beat at index arlen means the burst is already too long
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      exp_len <= '0;
      beat_cnt <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && |s_arvalid) grant <= pick;
      if (ar_hs) begin
        exp_len <= m_axi_arlen;
        beat_cnt <= '0;
      end
      if (r_hs) beat_cnt <= beat_cnt + 8'd1;
      if (r_hs && (m_axi_rlast ? beat_cnt != exp_len : beat_cnt == exp_len)) protocol_err <= 1'b1;
      if (r_hs && m_axi_rlast) last_grant <= grant;
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: requester/slave models with a beat scoreboard for axi_read_arbiter.
module tb_axi_read_arbiter;
  localparam int IW = 13, AW = 64, DW = 64;
  logic clk = 1'b0, reset = 1'b1;
  logic [2*IW-1:0] s_arid;
  logic [2*AW-1:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0] s_arsize, s_arprot;
  logic [3:0] s_arburst;
  logic [1:0] s_arlock, s_arvalid, s_arready, s_rresp, s_rvalid, s_rready;
  logic [7:0] s_arcache;
  logic [IW-1:0] s_rid, m_axi_arid, m_axi_rid;
  logic [DW-1:0] s_rdata, m_axi_rdata;
  logic s_rlast;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize, m_axi_arprot;
  logic [1:0] m_axi_arburst, m_axi_rresp;
  logic m_axi_arlock, m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [3:0] m_axi_arcache;
  logic grant, busy, protocol_err;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .grant(grant), .busy(busy), .protocol_err(protocol_err)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; logic [7:0] nb; } req_t;
  typedef struct packed { logic r; logic [DW-1:0] data; logic last; } beat_t;
  req_t rq0[$], rq1[$];
  beat_t exp_q[$];
  beat_t e_mon;
  int hs_log[$], gap_q[$];
  int n_checks = 0, n_fail = 0, cyc = 0, last_rlast_cyc = 0, beats_seen = 0;
  int stall_seen = 0, rr_low = 0, ar_stall = 0, hold1 = 0, short_nb = 0;
  logic stall_chk = 1'b0, rr_chk = 1'b0, prev_arv = 1'b0;
  logic [AW-1:0] stall_addr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic r, input req_t q);
    hs_log.push_back(int'(r));
    for (int k = 0; k < int'(q.nb); k++)
      exp_q.push_back({r, q.addr + AW'(k), k == int'(q.nb) - 1});
  endtask

  task automatic drive_ar(input int r, input req_t q);
    s_araddr[r*AW +: AW] = q.addr;
    s_arlen[r*8 +: 8] = q.len;
    s_arid[r*IW +: IW] = IW'(r + 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < budget && (busy || exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0));
    check("drain_pending", 64'(int'(busy) + exp_q.size() + rq0.size() + rq1.size()), 0);
  endtask

  task automatic wait_beats(input int target);
    for (int n = 0; n < 200 && beats_seen < target; n++) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, m_axi_arvalid, 0);
    check({tag, "_rready"}, m_axi_rready, 0);
    check({tag, "_s_arready"}, s_arready, 0);
    check({tag, "_s_rvalid"}, s_rvalid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_perr"}, protocol_err, 0);
    check({tag, "_grant"}, grant, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk) if (!reset) begin
    if (s_rvalid != 2'b00 && exp_q.size() == 0) check("r_unexpected", s_rvalid, 0);
    else if ((s_rvalid & s_rready) != 2'b00) begin
      e_mon = exp_q.pop_front();
      check("r_port", s_rvalid & s_rready, e_mon.r ? 2'b10 : 2'b01);
      check("rdata", s_rdata, e_mon.data);
      check("rlast", s_rlast, e_mon.last);
      check("rid", s_rid, IW'(e_mon.r) + IW'(1));
      beats_seen++;
    end
    if (m_axi_rvalid && m_axi_rready && m_axi_rlast) last_rlast_cyc = cyc;
    if (m_axi_arvalid && !prev_arv) gap_q.push_back(cyc - last_rlast_cyc);
    prev_arv = m_axi_arvalid;
    if (stall_chk && m_axi_arvalid && !m_axi_arready) begin
      stall_seen++;
      check("ar_hold_addr", m_axi_araddr, stall_addr);
      check("ar_hold_sready", s_arready, 0);
    end
    if (rr_chk && m_axi_rvalid && !s_rready[1]) begin
      rr_low++;
      check("rready_hold", m_axi_rready, 0);
    end
  end

  // requester agents
  initial begin
    logic hs0, hs1;
    s_arvalid = '0; s_rready = 2'b11; s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = 6'b011011; s_arburst = 4'b0101; s_arlock = '0; s_arcache = '0; s_arprot = '0;
    forever begin
      @(negedge clk);
      hs0 = s_arvalid[0] & s_arready[0] & !reset;
      hs1 = s_arvalid[1] & s_arready[1] & !reset;
      @(posedge clk);
      #1;
      if (hs0 && rq0.size() != 0) accept(1'b0, rq0.pop_front());
      if (hs1 && rq1.size() != 0) accept(1'b1, rq1.pop_front());
      s_arvalid = {rq1.size() != 0, rq0.size() != 0};
      if (rq0.size() != 0) drive_ar(0, rq0[0]);
      if (rq1.size() != 0) drive_ar(1, rq1[0]);
      s_rready[1] = hold1 == 0;
      if (hold1 > 0) hold1--;
    end
  end

  // memory slave: data = burst address + beat index
  initial begin
    logic sa, sahs, srhs, sl_act;
    logic [AW-1:0] sa_addr, sl_addr;
    logic [7:0] sa_len;
    logic [IW-1:0] sa_id, sl_id;
    int sl_beat, sl_nb;
    sl_act = 0; sl_addr = '0; sl_id = '0; sl_beat = 0; sl_nb = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0; m_axi_rid = '0; m_axi_rresp = '0;
    forever begin
      @(negedge clk);
      sa = m_axi_arvalid; sahs = m_axi_arvalid & m_axi_arready; srhs = m_axi_rvalid & m_axi_rready;
      sa_addr = m_axi_araddr; sa_len = m_axi_arlen; sa_id = m_axi_arid;
      @(posedge clk);
      #1;
      if (reset) begin
        sl_act = 0;
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_arready = 0;
      end else begin
        if (sahs) begin
          sl_act = 1; sl_addr = sa_addr; sl_id = sa_id; sl_beat = 0;
          sl_nb = short_nb != 0 ? short_nb : int'(sa_len) + 1;
          short_nb = 0;
        end else if (srhs) begin
          sl_beat++;
          if (sl_beat == sl_nb) sl_act = 0;
        end
        if (!sl_act && sa && ar_stall > 0) ar_stall--;
        m_axi_arready = !sl_act && ar_stall == 0;
        m_axi_rvalid = sl_act;
        m_axi_rdata = sl_addr + DW'(sl_beat);
        m_axi_rlast = sl_beat == sl_nb - 1;
        m_axi_rid = sl_id;
      end
    end
  end

  initial begin
    int b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    // simultaneous requests straight after reset: requester 0 first
    gap_q.delete(); hs_log.delete();
    rq0.push_back({64'h2000, 8'd3, 8'd4});
    rq1.push_back({64'h8000, 8'd5, 8'd6});
    drain(300);
    check("tie_count", hs_log.size(), 2);
    if (hs_log.size() == 2) begin
      check("tie_first", hs_log[0], 0);
      check("tie_second", hs_log[1], 1);
    end
    check("tie_gap_count", gap_q.size(), 2);
    if (gap_q.size() == 2) check("tie_ar_gap", gap_q[1], 2);
    check("tie_grant", grant, 1);
    // both continuously requesting: strict alternation
    hs_log.delete();
    for (int k = 0; k < 2; k++) begin
      rq0.push_back({64'h10000 + 64'(k * 'h100), 8'd1, 8'd2});
      rq1.push_back({64'h20000 + 64'(k * 'h100), 8'd1, 8'd2});
    end
    drain(400);
    check("rr_count", hs_log.size(), 4);
    for (int k = 0; k < 4 && k < hs_log.size(); k++) check("rr_order", hs_log[k], k % 2);
    check("rr_grant", grant, 1);
    // single 8-beat burst from requester 0
    b0 = beats_seen;
    rq0.push_back({64'h1000, 8'd7, 8'd8});
    drain(300);
    check("single_beats", beats_seen - b0, 8);
    check("single_perr", protocol_err, 0);
    check("single_busy", busy, 0);
    check("single_grant", grant, 0);
    // slave holds arready low for 5 cycles
    ar_stall = 5; stall_seen = 0; stall_addr = 64'h3000; stall_chk = 1;
    rq0.push_back({64'h3000, 8'd2, 8'd3});
    drain(300);
    stall_chk = 0;
    check("ar_stall_cycles", stall_seen, 5);
    // requester 1 drops rready for 3 cycles mid-burst
    b0 = beats_seen; rr_low = 0;
    rq1.push_back({64'h4000, 8'd7, 8'd8});
    wait_beats(b0 + 3);
    hold1 = 3; rr_chk = 1;
    drain(300);
    rr_chk = 0;
    check("rready_low_cycles", rr_low, 3);
    check("rready_beats", beats_seen - b0, 8);
    // early rlast: error is flagged and sticks across a clean burst
    short_nb = 4;
    rq0.push_back({64'h5000, 8'd7, 8'd4});
    drain(300);
    check("short_perr", protocol_err, 1);
    check("short_busy", busy, 0);
    rq1.push_back({64'h6000, 8'd1, 8'd2});
    drain(300);
    check("sticky_perr", protocol_err, 1);
    // reset in the middle of a burst
    b0 = beats_seen;
    rq0.push_back({64'h7000, 8'd7, 8'd8});
    wait_beats(b0 + 2);
    @(posedge clk);
    #1 reset = 1;
    rq0.delete(); rq1.delete();
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 reset = 0;
    exp_q.delete();
    // recovery burst after reset
    rq1.push_back({64'h9000, 8'd3, 8'd4});
    drain(300);
    check("post_rst_grant", grant, 1);
    check("post_rst_perr", protocol_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
